minimac_txframer: RTL



---
 rtl/minimac_txframer.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/minimac_txframer.sv
// rtl/minimac_txframer.sv - Ethernet TX frame builder: preamble, SFD, payload, optional pad, CRC-32 FCS
//
// Zero padding up to MIN_FRAME bytes is compiled in only when MINIMAC_TX_PAD_EN is defined.
//
// Ports:
//   sys_clk, sys_rst  clock; asynchronous active-high reset
//   start, tx_count   frame request pulse; payload length in bytes (latched on accept)
//   busy, done        frame in progress; one-cycle end-of-frame pulse
//   mem_adr, mem_dat  TX buffer read port (registered RAM, one-cycle read latency)
//   stb, data, full   FIFO write port; stb is registered and decided from the previous full
module minimac_txframer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [10:0] tx_count,
  output logic        busy,
  output logic        done,
  output logic [10:0] mem_adr,
  input  logic [7:0]  mem_dat,
  output logic        stb,
  output logic [7:0]  data,
  input  logic        full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_PAY,
`ifdef MINIMAC_TX_PAD_EN
    S_PAD,
`endif
    S_FCS
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
`ifdef MINIMAC_TX_PAD_EN
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
`else
  localparam int unused_min_frame = MIN_FRAME;
`endif

  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [10:0] idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;   // PAY: 0 = fetch cycle, 1 = mem_dat valid
  logic [31:0] crc_q, crc_d;
  logic [10:0] mem_adr_q, mem_adr_d;
  logic        stb_q, stb_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] idx_next;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32 (poly 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign idx_next = idx_q + 11'd1;

  // crc_q is not updated in FCS, so the transmitted value stays frozen for all four bytes.
  always_comb begin
    fcs_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0:    fcs_byte = ~crc_q[7:0];
      2'd1:    fcs_byte = ~crc_q[15:8];
      2'd2:    fcs_byte = ~crc_q[23:16];
      default: fcs_byte = ~crc_q[31:24];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    crc_d     = crc_q;
    mem_adr_d = mem_adr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    stb_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start landing in the done cycle is dropped and must be re-issued.
        if (start && !done_q) begin
          len_d     = tx_count;
          idx_d     = 11'd0;
          cnt_d     = 8'd0;
          crc_d     = 32'hFFFFFFFF;
          mem_adr_d = 11'd0;
          busy_d    = 1'b1;
          state_d   = S_PRE;
        end
      end

      S_PRE: begin
        if (!full) begin
          stb_d  = 1'b1;
          data_d = 8'h55;
          if (cnt_q == PRE_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_SFD: begin
        if (!full) begin
          stb_d   = 1'b1;
          data_d  = 8'hD5;
          // mem_adr has been 0 since the start, so byte 0 is already on mem_dat.
          phase_d = 1'b1;
          if (len_q != 11'd0) begin
            state_d = S_PAY;
          end else begin
`ifdef MINIMAC_TX_PAD_EN
            state_d = (MIN_LEN != 11'd0) ? S_PAD : S_FCS;
`else
            state_d = S_FCS;
`endif
          end
        end
      end

      S_PAY: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (!full) begin
          stb_d   = 1'b1;
          data_d  = mem_dat;
          crc_d   = crc32_byte(crc_q, mem_dat);
          idx_d   = idx_next;
          phase_d = 1'b0;
          if (idx_next == len_q) begin
`ifdef MINIMAC_TX_PAD_EN
            state_d = (idx_next < MIN_LEN) ? S_PAD : S_FCS;
`else
            state_d = S_FCS;
`endif
          end else begin
            // Address only advances while another payload byte remains, capping it at len-1.
            mem_adr_d = idx_next;
          end
        end
      end

`ifdef MINIMAC_TX_PAD_EN
      S_PAD: begin
        if (!full) begin
          stb_d  = 1'b1;
          data_d = 8'h00;
          crc_d  = crc32_byte(crc_q, 8'h00);
          idx_d  = idx_next;
          if (idx_next == MIN_LEN) begin
            state_d = S_FCS;
          end
        end
      end
`endif

      S_FCS: begin
        if (cnt_q == 8'd4) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (!full) begin
          stb_d  = 1'b1;
          data_d = fcs_byte;
          cnt_d  = cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      len_q     <= 11'd0;
      idx_q     <= 11'd0;
      cnt_q     <= 8'd0;
      phase_q   <= 1'b0;
      crc_q     <= 32'hFFFFFFFF;
      mem_adr_q <= 11'd0;
      stb_q     <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      crc_q     <= crc_d;
      mem_adr_q <= mem_adr_d;
      stb_q     <= stb_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mem_adr = mem_adr_q;
  assign stb     = stb_q;
  assign data    = data_q;

endmodule
